// File: rtl/tw_rom_seq_buf_if.sv
// Host/butterfly-side bundle for the twiddle buffer: load port, read controls and twiddle outputs.
// The master drives loads and read qualifiers; the slave (the buffer) returns twiddles and status.
interface tw_rom_seq_buf_if #(
  parameter int P_WIDTH  = 128,
  parameter int HW       = 64,
  parameter int SC_WIDTH = 3,
  parameter int AW       = 4,
  parameter int GW       = 2
);
  logic                CEN;
  logic [SC_WIDTH-1:0] stage_counter;
  logic                tw_en;
  logic [1:0]          wr_mode;
  logic                wr_tgt;
  logic [AW-1:0]       wr_addr;
  logic [HW-1:0]       horizontal_data_in;
  logic [P_WIDTH-1:0]  Q;
  logic [P_WIDTH-1:0]  Q_const;
  logic                q_valid;
  logic [GW-1:0]       group_idx;
  logic                sweep_done;

  modport master (
    output CEN, stage_counter, tw_en, wr_mode, wr_tgt, wr_addr, horizontal_data_in,
    input  Q, Q_const, q_valid, group_idx, sweep_done
  );

  modport slave (
    input  CEN, stage_counter, tw_en, wr_mode, wr_tgt, wr_addr, horizontal_data_in,
    output Q, Q_const, q_valid, group_idx, sweep_done
  );
endinterface

// File: rtl/tw_rom_seq_buf.sv
// Runtime-loadable twiddle table with per-stage constants, streamed to the radix-16 butterfly
// in entry/sweep/group order; group walking is enabled per stage by GROUP_MODE.
module tw_rom_seq_buf #(
  parameter int               P_WIDTH    = 128,
  parameter int               HW         = 64,
  parameter int               DEPTH      = 4,
  parameter int               NGROUP     = 4,
  parameter int               SWEEPS     = 16,
  parameter int               NSTAGE     = 3,
  parameter int               SC_WIDTH   = 3,
  parameter logic [NSTAGE-1:0] GROUP_MODE = 3'b010
) (
  input logic             CLK,
  input logic             rst_n,
  tw_rom_seq_buf_if.slave bus
);

  localparam int IW   = $clog2(DEPTH);
  localparam int AW   = $clog2(NGROUP * DEPTH);
  localparam int GW   = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam int SWW  = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
  localparam int NENT = NGROUP * DEPTH;

  localparam logic [IW-1:0]       IDX_LAST = IW'(DEPTH - 1);
  localparam logic [SWW-1:0]      SW_LAST  = SWW'(SWEEPS - 1);
  localparam logic [GW-1:0]       GRP_LAST = GW'(NGROUP - 1);
  localparam logic [SC_WIDTH-1:0] NSTAGE_C = SC_WIDTH'(NSTAGE);
  localparam logic [P_WIDTH-1:0]  LOW_ONE  = P_WIDTH'(1);
  localparam logic [P_WIDTH-1:0]  UNITY    = LOW_ONE | (LOW_ONE << HW);

  logic [P_WIDTH-1:0]  tbl [NENT];
  logic [P_WIDTH-1:0]  cst [NSTAGE];

  logic [SC_WIDTH-1:0] prev_stage;
  logic [IW-1:0]       idx;
  logic [SWW-1:0]      sweep;
  logic [GW-1:0]       grp;

  logic [P_WIDTH-1:0]  q_p1;
  logic [P_WIDTH-1:0]  q_const_p1;
  logic                vld_p1;
  logic                done_p1;

  logic                stg_ok;
  logic                stg_chg;
  logic                grp_en;
  logic [P_WIDTH-1:0]  cst_sel;
  logic [IW-1:0]       idx_eff;
  logic [SWW-1:0]      sw_eff;
  logic [GW-1:0]       grp_eff;
  logic                idx_wrap;
  logic                sw_wrap;
  logic [AW-1:0]       rd_addr;

  // A stage change zeroes the counters before they form this cycle's read address.
  always_comb begin
    stg_ok  = (bus.stage_counter < NSTAGE_C);
    stg_chg = (bus.stage_counter != prev_stage);
    grp_en  = 1'b0;
    cst_sel = cst[0];
    for (int s = 0; s < NSTAGE; s++) begin
      if (bus.stage_counter == SC_WIDTH'(s)) begin
        grp_en  = GROUP_MODE[s];
        cst_sel = cst[s];
      end
    end
    idx_eff  = stg_chg ? '0 : idx;
    sw_eff   = stg_chg ? '0 : sweep;
    grp_eff  = stg_chg ? '0 : grp;
    idx_wrap = (idx_eff == IDX_LAST);
    sw_wrap  = (sw_eff == SW_LAST);
    rd_addr  = AW'({grp_eff, idx_eff});
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) tbl[i] <= UNITY;
      for (int s = 0; s < NSTAGE; s++) cst[s] <= UNITY;
    end else if (bus.wr_tgt == 1'b0) begin
      if (bus.wr_mode == 2'd1)      tbl[bus.wr_addr][P_WIDTH-1:HW] <= bus.horizontal_data_in;
      else if (bus.wr_mode == 2'd2) tbl[bus.wr_addr][HW-1:0]       <= bus.horizontal_data_in;
    end else begin
      for (int s = 0; s < NSTAGE; s++) begin
        if (bus.wr_addr == AW'(s)) begin
          if (bus.wr_mode == 2'd1)      cst[s][P_WIDTH-1:HW] <= bus.horizontal_data_in;
          else if (bus.wr_mode == 2'd2) cst[s][HW-1:0]       <= bus.horizontal_data_in;
        end
      end
    end
  end

  // ---- stage p0 -> p1: sequencer update and registered read ----
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      prev_stage <= '0;
      idx        <= '0;
      sweep      <= '0;
      grp        <= '0;
      q_p1       <= '0;
      q_const_p1 <= '0;
      vld_p1     <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      prev_stage <= bus.stage_counter;
      done_p1    <= 1'b0;
      if (bus.CEN) begin
        q_p1   <= LOW_ONE;
        vld_p1 <= 1'b0;
        if (stg_chg) begin
          idx   <= '0;
          sweep <= '0;
          grp   <= '0;
        end
      end else if (!stg_ok) begin
        q_p1   <= LOW_ONE;
        vld_p1 <= 1'b0;
        idx    <= '0;
        sweep  <= '0;
        grp    <= '0;
      end else begin
        q_const_p1 <= cst_sel;
        if (!bus.tw_en) begin
          q_p1   <= LOW_ONE;
          vld_p1 <= 1'b0;
          idx    <= '0;
          sweep  <= '0;
          grp    <= grp_eff;
        end else begin
          q_p1   <= tbl[rd_addr];
          vld_p1 <= 1'b1;
          idx    <= idx_wrap ? '0 : idx_eff + 1'b1;
          sweep  <= sw_eff;
          grp    <= grp_eff;
          if (idx_wrap) begin
            sweep <= sw_wrap ? '0 : sw_eff + 1'b1;
            if (sw_wrap) begin
              done_p1 <= 1'b1;
              // Stages without group walking keep the pointer parked on group 0.
              grp     <= grp_en ? ((grp_eff == GRP_LAST) ? '0 : grp_eff + 1'b1) : '0;
            end
          end
        end
      end
    end
  end

  assign bus.Q          = q_p1;
  assign bus.Q_const    = q_const_p1;
  assign bus.q_valid    = vld_p1;
  assign bus.group_idx  = grp;
  assign bus.sweep_done = done_p1;

endmodule

// File: tb/tb_tw_rom_seq_buf.sv
// Scoreboard bench for tw_rom_seq_buf: a read-count reference model pushes expected outputs,
// a monitor pops and compares them one cycle later.
module tb_tw_rom_seq_buf;

  localparam int P_WIDTH  = 128;
  localparam int HW       = 64;
  localparam int DEPTH    = 4;
  localparam int NGROUP   = 4;
  localparam int SWEEPS   = 16;
  localparam int NSTAGE   = 3;
  localparam int SC_WIDTH = 3;
  localparam int AW       = 4;
  localparam int GW       = 2;
  localparam int NENT     = NGROUP * DEPTH;
  localparam int GROUP_WALK [NSTAGE] = '{0, 1, 0};

  localparam logic [127:0] UNITY = {64'd1, 64'd1};
  localparam logic [127:0] IDLE  = {64'd0, 64'd1};

  typedef struct packed {
    logic [127:0] q;
    logic [127:0] qc;
    logic         v;
    logic [1:0]   g;
    logic         d;
  } exp_t;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;

  tw_rom_seq_buf_if #(.P_WIDTH(P_WIDTH), .HW(HW), .SC_WIDTH(SC_WIDTH), .AW(AW), .GW(GW)) bus ();

  tw_rom_seq_buf #(
    .P_WIDTH(P_WIDTH), .HW(HW), .DEPTH(DEPTH), .NGROUP(NGROUP), .SWEEPS(SWEEPS),
    .NSTAGE(NSTAGE), .SC_WIDTH(SC_WIDTH), .GROUP_MODE(3'b010)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  exp_t sb [$];

  // Reference model: position counts qualified reads inside the current group.
  logic [127:0] m_tbl [NENT];
  logic [127:0] m_cst [NSTAGE];
  logic [127:0] m_q;
  logic [127:0] m_qc;
  int           m_pos;
  int           m_grp;
  int           m_prev;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_tbl[i] = UNITY;
    for (int s = 0; s < NSTAGE; s++) m_cst[s] = UNITY;
    m_q = '0; m_qc = '0; m_pos = 0; m_grp = 0; m_prev = 0;
  endtask

  task automatic cyc(input bit cen, input int stage, input bit twen,
                     input int wm = 0, input bit tgt = 1'b0, input int wa = 0,
                     input logic [63:0] wd = 64'd0);
    bit   v;
    bit   done;
    exp_t e;
    @(negedge CLK);
    rst_n = 1'b1;
    bus.CEN = cen;
    bus.stage_counter = 3'(stage);
    bus.tw_en = twen;
    bus.wr_mode = 2'(wm);
    bus.wr_tgt = tgt;
    bus.wr_addr = 4'(wa);
    bus.horizontal_data_in = wd;
    v = 1'b0;
    done = 1'b0;
    if (stage != m_prev) begin
      m_pos = 0;
      m_grp = 0;
    end
    m_prev = stage;
    if (cen) begin
      m_q = IDLE;
    end else if (stage >= NSTAGE) begin
      m_q = IDLE; m_pos = 0; m_grp = 0;
    end else begin
      m_qc = m_cst[stage];
      if (!twen) begin
        m_q = IDLE; m_pos = 0;
      end else begin
        m_q = m_tbl[m_grp * DEPTH + (m_pos % DEPTH)];
        v = 1'b1;
        m_pos++;
        if (m_pos == DEPTH * SWEEPS) begin
          m_pos = 0;
          done = 1'b1;
          m_grp = (GROUP_WALK[stage] != 0) ? (m_grp + 1) % NGROUP : 0;
        end
      end
    end
    // Writes land after the read, so a same-cycle read sees the old word.
    if (!tgt) begin
      if (wm == 1) m_tbl[wa][127:64] = wd;
      else if (wm == 2) m_tbl[wa][63:0] = wd;
    end else if (wa < NSTAGE) begin
      if (wm == 1) m_cst[wa][127:64] = wd;
      else if (wm == 2) m_cst[wa][63:0] = wd;
    end
    e.q = m_q; e.qc = m_qc; e.v = v; e.g = 2'(m_grp); e.d = done;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge CLK);
    rst_n = 1'b0;
    bus.CEN = 1'b1;
    bus.wr_mode = 2'd0;
    model_reset();
    e.q = '0; e.qc = '0; e.v = 1'b0; e.g = 2'd0; e.d = 1'b0;
    sb.push_back(e);
    #1;
    chk("async_rst_q", bus.Q, 128'd0);
    chk("async_rst_grp", 128'(bus.group_idx), 128'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.sweep_done === 1'b1) done_seen++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("Q", bus.Q, e.q);
        chk("Q_const", bus.Q_const, e.qc);
        chk("q_valid", 128'(bus.q_valid), 128'(e.v));
        chk("group_idx", 128'(bus.group_idx), 128'(e.g));
        chk("sweep_done", 128'(bus.sweep_done), 128'(e.d));
      end
    end
  end

  initial begin
    int d0;
    int stage;
    int wm;
    bus.CEN = 1'b1;
    bus.stage_counter = '0;
    bus.tw_en = 1'b0;
    bus.wr_mode = 2'd0;
    bus.wr_tgt = 1'b0;
    bus.wr_addr = '0;
    bus.horizontal_data_in = '0;
    model_reset();
    #2;
    chk("rst_Q", bus.Q, 128'd0);
    chk("rst_Q_const", bus.Q_const, 128'd0);
    chk("rst_q_valid", 128'(bus.q_valid), 128'd0);
    chk("rst_group_idx", 128'(bus.group_idx), 128'd0);
    chk("rst_sweep_done", 128'(bus.sweep_done), 128'd0);

    repeat (8) cyc(1'b0, 0, 1'b1);

    // High half of entry 5 (group 1, idx 1), then low half while that entry is being read.
    cyc(1'b1, 0, 1'b0, 1, 1'b0, 5, 64'hAAAA_AAAA_AAAA_AAAA);
    d0 = done_seen;
    repeat (65) cyc(1'b0, 1, 1'b1);
    cyc(1'b0, 1, 1'b1, 2, 1'b0, 5, 64'h5555_5555_5555_5555);
    repeat (234) cyc(1'b0, 1, 1'b1);
    cyc(1'b1, 1, 1'b0);
    chk("stage1_done_pulses", 128'(done_seen - d0), 128'd4);

    cyc(1'b1, 1, 1'b0, 1, 1'b1, 0, 64'hC0C0_0000_0000_0001);
    cyc(1'b1, 1, 1'b0, 2, 1'b1, 2, 64'h0000_0000_0000_0C22);
    cyc(1'b1, 1, 1'b0, 1, 1'b1, 3, 64'hDEAD_BEEF_DEAD_BEEF);
    d0 = done_seen;
    repeat (66) cyc(1'b0, 2, 1'b1);
    cyc(1'b0, 2, 1'b0);
    repeat (3) cyc(1'b0, 2, 1'b1);
    cyc(1'b1, 2, 1'b0);
    chk("stage2_done_pulses", 128'(done_seen - d0), 128'd1);

    repeat (3) cyc(1'b0, 5, 1'b1);
    repeat (5) cyc(1'b0, 0, 1'b1);

    cyc(1'b1, 0, 1'b0, 1, 1'b0, 0, 64'h1234_5678_9ABC_DEF0);
    cyc(1'b1, 0, 1'b0, 2, 1'b0, 0, 64'h0FED_CBA9_8765_4321);
    repeat (100) cyc(1'b0, 1, 1'b1);
    do_reset();
    repeat (4) cyc(1'b0, 1, 1'b1);

    stage = 0;
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) stage = $urandom_range(0, 5);
      wm = $urandom_range(0, 5);
      if (wm > 2) wm = 0;
      cyc(($urandom_range(0, 9) == 0), stage, ($urandom_range(0, 11) != 0), wm,
          1'($urandom_range(0, 1)), $urandom_range(0, 15), {$urandom, $urandom});
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge CLK);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
